// File: rtl/sg13g2_io_pkg.sv
// sg13g2_io_pkg: shared defaults and the filter-to-status edge type for the GPIO bank.
package sg13g2_io_pkg;
    localparam int NCH_DEF = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_W_DEF = 4;
    typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_t;
endpackage

// File: rtl/sg13g2_io_in_filter.sv
// sg13g2_io_in_filter: one-channel pad input synchroniser, debounce counter and edge detect.
module sg13g2_io_in_filter
    import sg13g2_io_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p2c,
    input  logic [DEB_W-1:0] deb_len,
    output logic             gpi,
    output edge_t            evt
);
    logic [SYNC_STAGES-1:0] sync;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W:0] nxt;
    logic s, diff, commit;
    // nxt is one bit wider so the threshold compare can never see a wrapped count
    always_comb begin
        s = sync[SYNC_STAGES-1];
        diff = s ^ gpi;
        nxt = {1'b0, cnt} + (DEB_W+1)'(1);
        commit = diff && (nxt >= {1'b0, deb_len});
        evt = commit ? (s ? EDGE_RISE : EDGE_FALL) : EDGE_NONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt <= '0;
            gpi <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], p2c};
            cnt <= (!diff || commit) ? '0 : nxt[DEB_W-1:0];
            if (commit) gpi <= s;
        end
    end
endmodule

// File: rtl/sg13g2_io_gpio_bank.sv
// sg13g2_io_gpio_bank: N-channel GPIO bank with registered pad outputs, filtered inputs
// and sticky maskable edge interrupts.
module sg13g2_io_gpio_bank
    import sg13g2_io_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   gpo,
    input  logic [NCH-1:0]   gpo_en,
    input  logic [DEB_W-1:0] deb_len,
    input  logic [NCH-1:0]   irq_rise_en,
    input  logic [NCH-1:0]   irq_fall_en,
    input  logic [NCH-1:0]   irq_clr,
    input  logic [NCH-1:0]   p2c,
    output logic [NCH-1:0]   c2p,
    output logic [NCH-1:0]   c2p_en,
    output logic [NCH-1:0]   gpi,
    output logic [NCH-1:0]   irq_stat,
    output logic             irq
);
    edge_t evt [NCH];
    logic [NCH-1:0] set;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sg13g2_io_in_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W)) u_filt (
            .clk(clk), .rst_n(rst_n), .p2c(p2c[i]), .deb_len(deb_len),
            .gpi(gpi[i]), .evt(evt[i])
        );
    end
    always_comb begin
        set = '0;
        for (int k = 0; k < NCH; k++)
            set[k] = (evt[k] == EDGE_RISE && irq_rise_en[k]) || (evt[k] == EDGE_FALL && irq_fall_en[k]);
    end
    // set is OR-ed after the clear mask so a same-edge event survives its clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c2p <= '0;
            c2p_en <= '0;
            irq_stat <= '0;
        end else begin
            c2p <= gpo;
            c2p_en <= gpo_en;
            irq_stat <= (irq_stat & ~irq_clr) | set;
        end
    end
    assign irq = |irq_stat;
endmodule

// File: tb/tb_sg13g2_io_gpio_bank.sv
// tb_sg13g2_io_gpio_bank: directed and random checks of the GPIO bank against a delay-line
// plus run-length reference model.
module tb_sg13g2_io_gpio_bank;
    localparam int NCH = 8;
    localparam int SS = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] gpo = '0, gpo_en = '0, irq_rise_en = '0, irq_fall_en = '0, irq_clr = '0, p2c = '0;
    logic [3:0] deb_len = 4'd4;
    logic [NCH-1:0] c2p, c2p_en, gpi, irq_stat;
    logic irq;
    int checks = 0;
    int failures = 0;

    logic [NCH-1:0] dly [$];
    int run [NCH];
    logic [NCH-1:0] gpi_m, stat_m, c2p_m, en_m;

    sg13g2_io_gpio_bank #(.NCH(NCH), .SYNC_STAGES(SS), .DEB_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .gpo(gpo), .gpo_en(gpo_en), .deb_len(deb_len),
        .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .irq_clr(irq_clr),
        .p2c(p2c), .c2p(c2p), .c2p_en(c2p_en), .gpi(gpi), .irq_stat(irq_stat), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        dly.delete();
        for (int i = 0; i < SS; i++) dly.push_back('0);
        for (int i = 0; i < NCH; i++) run[i] = 0;
        gpi_m = '0;
        stat_m = '0;
        c2p_m = '0;
        en_m = '0;
    endtask

    task automatic compare_all();
        chk("c2p", 32'(c2p), 32'(c2p_m));
        chk("c2p_en", 32'(c2p_en), 32'(en_m));
        chk("gpi", 32'(gpi), 32'(gpi_m));
        chk("irq_stat", 32'(irq_stat), 32'(stat_m));
        chk("irq", 32'(irq), 32'(|stat_m));
    endtask

    // p2c reaches the filter after SS edges; gpi follows once s has differed for deb_len edges
    task automatic step();
        logic [NCH-1:0] s, set;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            s = dly.pop_front();
            dly.push_back(p2c);
            set = '0;
            for (int i = 0; i < NCH; i++) begin
                if (s[i] != gpi_m[i]) begin
                    run[i]++;
                    if (run[i] >= int'(deb_len)) begin
                        gpi_m[i] = s[i];
                        run[i] = 0;
                        set[i] = s[i] ? irq_rise_en[i] : irq_fall_en[i];
                    end
                end else run[i] = 0;
            end
            stat_m = (stat_m & ~irq_clr) | set;
            c2p_m = gpo;
            en_m = gpo_en;
        end
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        bit seen;
        model_reset();
        gpo = NCH'($urandom); gpo_en = NCH'($urandom); p2c = NCH'($urandom);
        irq_rise_en = NCH'($urandom); irq_clr = NCH'($urandom);
        #3;
        chk("rst_c2p", 32'(c2p), 0);
        chk("rst_gpi", 32'(gpi), 0);
        chk("rst_irq", 32'(irq), 0);
        repeat (3) step();
        p2c = '0; irq_clr = '0; irq_rise_en = '0; irq_fall_en = '0; deb_len = 4'd4;
        rst_n = 1'b1;
        repeat (4) step();
        gpo = 8'hA5; gpo_en = 8'hF0;
        step();
        chk("out_c2p", 32'(c2p), 32'h A5);
        chk("out_c2p_en", 32'(c2p_en), 32'h F0);

        irq_rise_en = 8'h01; p2c[0] = 1'b1;
        for (n = 1; n <= 20; n++) begin
            step();
            if (gpi[0]) break;
        end
        chk("accept_latency", 32'(n), 6);
        chk("accept_stat", 32'(irq_stat[0]), 1);
        chk("accept_irq", 32'(irq), 1);

        irq_clr = '1; step(); irq_clr = '0;
        irq_rise_en = 8'h08; p2c[3] = 1'b1;
        repeat (3) step();
        p2c[3] = 1'b0;
        seen = 0;
        repeat (10) begin step(); seen |= gpi[3]; end
        chk("glitch_gpi", 32'(seen), 0);
        chk("glitch_stat", 32'(irq_stat[3]), 0);
        p2c[3] = 1'b1;
        repeat (4) step();
        p2c[3] = 1'b0;
        seen = 0;
        repeat (6) begin step(); seen |= gpi[3]; end
        chk("pulse4_seen", 32'(seen), 1);
        chk("pulse4_stat", 32'(irq_stat[3]), 1);
        repeat (8) step();

        irq_rise_en = '0; irq_fall_en = 8'h01; p2c[1:0] = 2'b11;
        repeat (10) step();
        irq_clr = '1; step(); irq_clr = '0;
        p2c[1:0] = 2'b00;
        repeat (10) step();
        chk("fall_mask", 32'(irq_stat), 32'h01);

        irq_clr = '1; step(); irq_clr = '0;
        irq_fall_en = '0; irq_rise_en = 8'h04; p2c[2] = 1'b1;
        repeat (5) step();
        irq_clr = 8'h04;
        step();
        chk("race_gpi", 32'(gpi[2]), 1);
        chk("race_stat", 32'(irq_stat[2]), 1);
        step();
        chk("late_clr", 32'(irq_stat[2]), 0);
        irq_clr = '0;

        deb_len = 4'd15; p2c[4] = 1'b1;
        repeat (11) step();
        chk("thr_hold", 32'(gpi[4]), 0);
        deb_len = 4'd3;
        step();
        chk("thr_commit", 32'(gpi[4]), 1);
        deb_len = 4'd0; p2c[5] = 1'b1;
        repeat (2) step();
        chk("len0_hold", 32'(gpi[5]), 0);
        step();
        chk("len0_commit", 32'(gpi[5]), 1);

        for (int c = 0; c < 400; c++) begin
            gpo = NCH'($urandom); gpo_en = NCH'($urandom);
            p2c ^= NCH'($urandom & $urandom & $urandom);
            irq_clr = NCH'($urandom & $urandom & $urandom);
            if (c % 40 == 0) begin
                deb_len = 4'($urandom_range(0, 6));
                irq_rise_en = NCH'($urandom); irq_fall_en = NCH'($urandom);
            end
            if (c == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_gpi", 32'(gpi), 0);
                chk("mid_rst_stat", 32'(irq_stat), 0);
                chk("mid_rst_c2p_en", 32'(c2p_en), 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
